tx_axis_arbiter: RTL and testbench
==================================

# tx_axis_arbiter

Frame-granular round-robin arbiter that shares the single AXIS slave input of the transmit MAC among `NUM_PORTS` independent frame sources. Once a port is granted, the grant is held until that port's `tlast` beat is accepted, so frames are never interleaved. The block also provides per-port enable masking, a grant/frame-done status, and a sticky over-length detector. It sits directly upstream of the transmit MAC in the `tx_clk` domain.

## Interface
- `NUM_PORTS`, 4: number of requesters, range 2–8.
- `AXIS_DATA_WIDTH`, 32: data width per port and at the output.
- `AXIS_DATA_BYTES`, `AXIS_DATA_WIDTH/8`: tkeep width.
- `MAX_FRAME_WORDS`, 380: beats per frame above which the over-length flag is set.
- `tx_clk` in, 1: clock. Single clock domain.
- `tx_rst` in, 1: reset, asynchronous, active-low.
- `s_tdata` in, `NUM_PORTS*AXIS_DATA_WIDTH`: port i occupies slice `[i*W +: W]`.
- `s_tkeep` in, `NUM_PORTS*AXIS_DATA_BYTES`: per-port tkeep, sliced the same way.
- `s_tvalid` in, `NUM_PORTS`: per-port valid.
- `s_tlast` in, `NUM_PORTS`: per-port last.
- `s_tready` out, `NUM_PORTS`: per-port ready.
- `m_tdata` out, `AXIS_DATA_WIDTH`: to the MAC.
- `m_tkeep` out, `AXIS_DATA_BYTES`: to the MAC.
- `m_tvalid` out, 1: to the MAC.
- `m_tlast` out, 1: to the MAC.
- `m_tready` in, 1: from the MAC.
- `cfg_port_en` in, `NUM_PORTS`: a port is eligible for a new grant only while its bit is set.
- `cfg_overlen_clr` in, 1: pulse; clears all `stat_overlen` bits.
- `stat_grant` out, `NUM_PORTS`: one-hot current grant; all zero when idle.
- `stat_busy` out, 1: a frame is in progress.
- `stat_frame_done` out, 1: one-cycle pulse when a frame completes.
- `stat_frame_port` out, `$clog2(NUM_PORTS)`: index of the port whose frame completed; valid while `stat_frame_done` is high.
- `stat_overlen` out, `NUM_PORTS`: sticky per-port over-length flags.

## Operation
- **FSM states:** IDLE and GRANT.
  - **IDLE:** `req = s_tvalid & cfg_port_en`. If `req != 0`, choose the first set bit of `req`, searching upward from `rr_ptr` and wrapping modulo `NUM_PORTS`. Register the one-hot grant, clear `beat_cnt`, and go to GRANT.
  - **GRANT:** on the beat where `m_tvalid & m_tready & m_tlast`, go to IDLE, set `rr_ptr = granted_index + 1` (wrapping), and pulse `stat_frame_done` with `stat_frame_port = granted_index`.
- **Datapath:** combinational mux selected by the registered grant. No data registers.
  - `m_tvalid = stat_busy & s_tvalid[g]`
  - `m_tdata`, `m_tkeep`, `m_tlast` = slice g
  - `s_tready[i] = stat_busy & grant[i] & m_tready`
  - In IDLE, `m_tvalid = 0`, `m_tlast = 0`, and `s_tready = 0`.
- **Enable changes:** clearing `cfg_port_en` while that port holds the grant does not interrupt its frame. The frame runs to `tlast`; the port is then skipped in later arbitration.
- **Over-length:**
  - `beat_cnt` counts accepted beats in GRANT and saturates at `MAX_FRAME_WORDS+1`.
  - When a beat is accepted with `beat_cnt >= MAX_FRAME_WORDS`, set `stat_overlen[g]`. The frame is still forwarded unchanged.
  - `cfg_overlen_clr` clears all bits. If a set and a clear land in the same cycle, the set wins for that bit.
- **Reset values:** state IDLE, `rr_ptr = 0`, grant = 0, `beat_cnt = 0`, `stat_overlen = 0`, `stat_frame_done = 0`, `stat_frame_port = 0`. Consequently `m_tvalid`, `m_tlast`, `s_tready`, `stat_busy` and `stat_grant` are all 0.
- **Reset mid-frame:** everything returns to reset values immediately (asynchronous). The partial frame is abandoned; re-framing is the source's responsibility.

## Timing
- **Grant latency:** `s_tvalid` sampled in IDLE at cycle N gives the grant at N+1, with `m_tvalid` combinationally high at N+1.
- **Back-to-back frames:** exactly one IDLE cycle separates the `tlast` beat and the next grant. Peak utilisation is therefore (frame beats)/(frame beats + 1).
- **Completion:** `stat_frame_done` is registered and asserts the cycle after the `tlast` handshake, coincident with IDLE.
- **Backpressure:** `m_tready` low in GRANT stalls the granted port combinationally. The grant and `beat_cnt` hold.
- **Output stability:** `m_tdata`, `m_tkeep` and `m_tlast` follow the granted source and must remain stable while `m_tvalid & !m_tready`. This is the source's AXIS obligation; the block adds no state that could violate it.

## Test plan
- **Reset:** with `tx_rst=0` applied asynchronously mid-frame, all `s_tready` are 0, `m_tvalid` is 0, and `stat_grant` is 0 within the same cycle. After release, the first grant goes to port 0 when all ports request.
- **Round-robin fairness:** all 4 ports hold 3-beat frames continuously. Grants follow the order 0,1,2,3,0, and each frame is followed by one idle cycle. `stat_frame_port` reads 0,1,2,3.
- **No interleave under backpressure:** port 1 sends an 8-beat frame with `m_tready` toggling 1010…, and port 2 requests mid-frame. Output carries all 8 beats of port 1 contiguous and in order, and port 2 is granted only the cycle after IDLE.
- **Enable masking:** with `cfg_port_en = 4'b1011` and all ports requesting, port 2 is never granted. Clearing bit 0 mid-frame of port 0 still completes that frame, and port 0 is skipped afterward.
- **Over-length:** with `MAX_FRAME_WORDS = 4`, a 5-beat frame on port 3 sets `stat_overlen[3]` on beat 5 and all 5 beats are forwarded. `cfg_overlen_clr` asserted on the same cycle as that set leaves the bit at 1; a later `cfg_overlen_clr` clears it.
- **Single requester:** only port 2 requests, sending a 1-beat frame with `tlast`. `m_tvalid` is high on exactly one cycle, `stat_frame_done` pulses next cycle with `stat_frame_port = 2`, and `rr_ptr` becomes 3.

Source files
------------

// File: rtl/tx_axis_arbiter.sv
// tx_axis_arbiter
//   Frame-granular round-robin arbiter in front of the transmit MAC. Several
//   AXI-Stream frame sources share one AXIS output. A grant is held from the
//   first beat until the granted port's tlast beat is accepted, so frames are
//   never interleaved. The output datapath is a pure mux and adds no latency.
//
// Ports
//   tx_clk, tx_rst          clock, asynchronous active-low reset
//   s_tdata/tkeep/tvalid/   per-port AXIS slave inputs; port i uses slice i
//   s_tlast, s_tready
//   m_tdata/tkeep/tvalid/   AXIS master output toward the MAC
//   m_tlast, m_tready
//   cfg_port_en             per-port eligibility for new grants
//   cfg_overlen_clr         pulse: clear all sticky over-length flags
//   stat_grant              one-hot current grant (zero when idle)
//   stat_busy               a frame is in progress
//   stat_frame_done         one-cycle pulse after a frame's tlast handshake
//   stat_frame_port         port index of the frame that just completed
//   stat_overlen            sticky per-port over-length flags
module tx_axis_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
  parameter int MAX_FRAME_WORDS = 380
) (
  input  logic                                   tx_clk,
  input  logic                                   tx_rst,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0]   s_tkeep,
  input  logic [NUM_PORTS-1:0]                   s_tvalid,
  input  logic [NUM_PORTS-1:0]                   s_tlast,
  output logic [NUM_PORTS-1:0]                   s_tready,
  output logic [AXIS_DATA_WIDTH-1:0]             m_tdata,
  output logic [AXIS_DATA_BYTES-1:0]             m_tkeep,
  output logic                                   m_tvalid,
  output logic                                   m_tlast,
  input  logic                                   m_tready,
  input  logic [NUM_PORTS-1:0]                   cfg_port_en,
  input  logic                                   cfg_overlen_clr,
  output logic [NUM_PORTS-1:0]                   stat_grant,
  output logic                                   stat_busy,
  output logic                                   stat_frame_done,
  output logic [$clog2(NUM_PORTS)-1:0]           stat_frame_port,
  output logic [NUM_PORTS-1:0]                   stat_overlen
);

  localparam int          PW = $clog2(NUM_PORTS);
  localparam int          CW = $clog2(MAX_FRAME_WORDS + 2);
  localparam int unsigned NP = NUM_PORTS;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_nxt;
  logic [NUM_PORTS-1:0] grant, grant_nxt;
  logic [PW-1:0]        rr_ptr, rr_nxt;
  logic [CW-1:0]        beat_cnt, cnt_nxt;
  logic [NUM_PORTS-1:0] overlen_nxt;
  logic                 done_nxt;
  logic [PW-1:0]        done_port_nxt;

  logic [NUM_PORTS-1:0] req;
  logic [PW-1:0]        gidx, pick;
  logic                 pick_ok;
  logic                 busy, accept;
  int unsigned          idx;

  assign busy = (state == GRANT);
  assign req  = s_tvalid & cfg_port_en;

  // Encode the registered one-hot grant into an index for the datapath mux.
  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
  end

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NP; k++) begin
      idx = (32'(rr_ptr) + k) % NP;
      if (!pick_ok && req[idx]) begin
        pick    = PW'(idx);
        pick_ok = 1'b1;
      end
    end
  end

  assign m_tvalid = busy & s_tvalid[gidx];
  assign m_tlast  = busy & s_tlast[gidx];
  assign m_tdata  = s_tdata[32'(gidx)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign m_tkeep  = s_tkeep[32'(gidx)*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
  assign s_tready = grant & {NUM_PORTS{busy & m_tready}};
  assign accept   = m_tvalid & m_tready;

  assign stat_grant = grant;
  assign stat_busy  = busy;

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_nxt        = rr_ptr;
    cnt_nxt       = beat_cnt;
    done_nxt      = 1'b0;
    done_port_nxt = stat_frame_port;
    // Clear first so that a same-cycle set below takes priority.
    overlen_nxt   = cfg_overlen_clr ? '0 : stat_overlen;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt = GRANT;
          grant_nxt = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          if (beat_cnt >= CW'(MAX_FRAME_WORDS)) overlen_nxt[gidx] = 1'b1;
          if (beat_cnt <= CW'(MAX_FRAME_WORDS)) cnt_nxt = beat_cnt + 1'b1;
          if (m_tlast) begin
            state_nxt     = IDLE;
            grant_nxt     = '0;
            rr_nxt        = (32'(gidx) == NP - 1) ? '0 : gidx + 1'b1;
            done_nxt      = 1'b1;
            done_port_nxt = gidx;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge tx_rst) begin
    if (!tx_rst) begin
      state           <= IDLE;
      grant           <= '0;
      rr_ptr          <= '0;
      beat_cnt        <= '0;
      stat_overlen    <= '0;
      stat_frame_done <= 1'b0;
      stat_frame_port <= '0;
    end else begin
      state           <= state_nxt;
      grant           <= grant_nxt;
      rr_ptr          <= rr_nxt;
      beat_cnt        <= cnt_nxt;
      stat_overlen    <= overlen_nxt;
      stat_frame_done <= done_nxt;
      stat_frame_port <= done_port_nxt;
    end
  end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Testbench for tx_axis_arbiter: randomized AXIS sources, a frame-level
// arbitration reference model, and a scoreboard monitor that compares every
// output handshake, grant and frame completion against expected queues.
module tb_tx_axis_arbiter;
  localparam int N    = 4;
  localparam int W    = 32;
  localparam int B    = 4;
  localparam int MAXW = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic [B-1:0] k;
    logic         l;
  } beat_t;

  logic             tx_clk = 1'b0;
  logic             tx_rst = 1'b1;
  logic [N*W-1:0]   s_tdata = '0;
  logic [N*B-1:0]   s_tkeep = '0;
  logic [N-1:0]     s_tvalid = '0;
  logic [N-1:0]     s_tlast = '0;
  logic [N-1:0]     s_tready;
  logic [W-1:0]     m_tdata;
  logic [B-1:0]     m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready = 1'b0;
  logic [N-1:0]     cfg_port_en = '1;
  logic             cfg_overlen_clr = 1'b0;
  logic [N-1:0]     stat_grant;
  logic             stat_busy;
  logic             stat_frame_done;
  logic [1:0]       stat_frame_port;
  logic [N-1:0]     stat_overlen;

  tx_axis_arbiter #(
    .NUM_PORTS(N), .AXIS_DATA_WIDTH(W), .AXIS_DATA_BYTES(B), .MAX_FRAME_WORDS(MAXW)
  ) dut (
    .tx_clk(tx_clk), .tx_rst(tx_rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .cfg_port_en(cfg_port_en), .cfg_overlen_clr(cfg_overlen_clr),
    .stat_grant(stat_grant), .stat_busy(stat_busy), .stat_frame_done(stat_frame_done),
    .stat_frame_port(stat_frame_port), .stat_overlen(stat_overlen)
  );

  always #5 tx_clk = ~tx_clk;

  int nchecks = 0;
  int nerr    = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Sources and reference model state
  beat_t        src_q [N][$];
  logic [N-1:0] hold = '0;
  int           fid = 0;
  int           vprob = 100;
  int           rdy_mode = 0;   // 0 always ready, 1 random, 2 toggle
  int           clr_mode = 0;   // 0 random by clr_pct, 1 one-shot, 2 on predicted set
  int           clr_pct = 0;
  logic [N-1:0] en = '1;

  logic         m_busy = 1'b0;
  int           m_port = 0;
  int           m_rr = 0;
  int           m_cnt = 0;
  logic [N-1:0] m_ov = '0;

  logic         exp_mvalid = 1'b0;
  logic         exp_busy = 1'b0;
  logic [N-1:0] exp_sready = '0;
  beat_t        exp_beats [$];
  int           exp_grant [$];
  int           exp_done [$];

  // Monitor-side observations
  logic         mon_en = 1'b0;
  logic         prev_busy = 1'b0;
  int           done_log [$];
  int           g_cnt [N];
  int           tv_cnt = 0;
  beat_t        mb;
  int           mi;

  initial for (int i = 0; i < N; i++) g_cnt[i] = 0;

  function automatic int log_at(input int i);
    return (i < done_log.size()) ? done_log[i] : 99;
  endfunction

  task automatic add_frame(input int p, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.d = {8'(p), 8'(fid), 16'(b)};
      bt.k = 4'($urandom);
      bt.l = (b == len - 1);
      src_q[p].push_back(bt);
    end
    fid++;
  endtask

  task automatic step();
    logic [N-1:0] vld;
    logic [N-1:0] ov_new;
    logic         set;
    logic         found;
    int           hs;
    int           w;
    beat_t        bt;
    vld = '0; hs = -1; found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && (hold[i] || $urandom_range(99) < vprob)) vld[i] = 1'b1;
      if (vld[i]) begin
        bt = src_q[i][0];
        s_tdata[i*W +: W] = bt.d;
        s_tkeep[i*B +: B] = bt.k;
        s_tlast[i]        = bt.l;
      end else begin
        s_tdata[i*W +: W] = $urandom;
        s_tkeep[i*B +: B] = 4'($urandom);
        s_tlast[i]        = 1'($urandom);
      end
    end
    s_tvalid = vld;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ($urandom_range(99) < 75);
      default: m_tready = ~m_tready;
    endcase
    cfg_port_en = en;
    exp_busy   = m_busy;
    exp_mvalid = m_busy && vld[m_port];
    exp_sready = (m_busy && m_tready) ? (N'(1) << m_port) : '0;
    set = exp_mvalid && m_tready && (m_cnt >= MAXW);
    if (clr_mode == 2)      cfg_overlen_clr = set;
    else if (clr_mode == 1) cfg_overlen_clr = 1'b1;
    else                    cfg_overlen_clr = ($urandom_range(99) < clr_pct);
    if (clr_mode == 1) clr_mode = 0;
    ov_new = cfg_overlen_clr ? '0 : m_ov;
    if (set) ov_new[m_port] = 1'b1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        w = (m_rr + k) % N;
        if (!found && vld[w] && en[w]) begin
          found = 1'b1; m_busy = 1'b1; m_port = w; m_cnt = 0;
          exp_grant.push_back(w);
        end
      end
    end else if (exp_mvalid && m_tready) begin
      bt = src_q[m_port][0];
      exp_beats.push_back(bt);
      hs = m_port;
      m_cnt++;
      if (bt.l) begin
        m_busy = 1'b0;
        m_rr   = (m_port + 1) % N;
        exp_done.push_back(m_port);
      end
    end
    for (int i = 0; i < N; i++) hold[i] = vld[i] && (i != hs);
    @(posedge tx_clk);
    #1;
    if (hs >= 0) src_q[hs].delete(0);
    m_ov = ov_new;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    tx_rst = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_stat_grant", stat_grant, 0);
    chk("rst_stat_busy", stat_busy, 0);
    chk("rst_frame_done", stat_frame_done, 0);
    chk("rst_overlen", stat_overlen, 0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    hold = '0; s_tvalid = '0; m_tready = 1'b0; cfg_overlen_clr = 1'b0;
    exp_beats.delete(); exp_grant.delete(); exp_done.delete();
    m_busy = 1'b0; m_rr = 0; m_cnt = 0; m_ov = '0;
    exp_mvalid = 1'b0; exp_busy = 1'b0; exp_sready = '0; prev_busy = 1'b0;
    @(posedge tx_clk);
    @(negedge tx_clk);
    tx_rst = 1'b1;
    @(posedge tx_clk);
    #1;
    mon_en = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge tx_clk) begin
    if (mon_en) begin
      chk("m_tvalid", m_tvalid, exp_mvalid);
      chk("stat_busy", stat_busy, exp_busy);
      chk("s_tready", s_tready, exp_sready);
      chk("stat_overlen", stat_overlen, m_ov);
      if (m_tvalid) tv_cnt++;
      if (m_tvalid && m_tready) begin
        if (exp_beats.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          mb = exp_beats.pop_front();
          chk("beat", {m_tdata, m_tkeep, m_tlast}, {mb.d, mb.k, mb.l});
        end
      end
      if (stat_busy && !prev_busy) begin
        for (int i = 0; i < N; i++) if (stat_grant[i]) g_cnt[i]++;
        if (exp_grant.size() == 0) chk("grant_unexpected", stat_grant, 0);
        else begin
          mi = exp_grant.pop_front();
          chk("grant", stat_grant, N'(1) << mi);
        end
      end
      if (stat_frame_done) begin
        done_log.push_back(int'(stat_frame_port));
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mi = exp_done.pop_front();
          chk("frame_port", stat_frame_port, mi);
        end
      end
      prev_busy = stat_busy;
    end
  end

  int g0s, g2s, c;

  initial begin
    #2;
    do_reset();

    // Fairness: all ports hold 3-beat frames
    en = '1; vprob = 100; rdy_mode = 0;
    for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) add_frame(p, 3);
    done_log.delete();
    run(40);
    chk("fair_count", done_log.size(), 8);
    for (int i = 0; i < 4; i++) chk("fair_order", log_at(i), i);

    // No interleave under toggling backpressure
    done_log.delete();
    add_frame(1, 8);
    rdy_mode = 2;
    run(3);
    add_frame(2, 2);
    run(40);
    chk("bp_first", log_at(0), 1);
    chk("bp_second", log_at(1), 2);

    // Enable masking
    rdy_mode = 0; en = 4'b1011;
    g2s = g_cnt[2];
    for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) add_frame(p, 3);
    for (c = 0; c < 200 && !(m_busy && m_port == 0); c++) step();
    chk("en_p0_granted", (m_busy && m_port == 0), 1);
    g0s = g_cnt[0];
    en = 4'b1010;
    run(60);
    chk("en_p2_never", g_cnt[2], g2s);
    chk("en_p0_skipped", g_cnt[0], g0s + 1);
    en = '1;
    run(60);

    // Over-length: 5-beat frame, clear collides with set
    add_frame(3, 5);
    clr_mode = 2;
    run(8);
    clr_mode = 0;
    chk("ovl_set_wins", stat_overlen[3], 1);
    run(2);
    clr_mode = 1;
    step();
    chk("ovl_cleared", stat_overlen[3], 0);

    // Single requester, then rr pointer must start at 3
    done_log.delete(); tv_cnt = 0;
    add_frame(2, 1);
    run(6);
    chk("single_tvalid_cycles", tv_cnt, 1);
    chk("single_port", log_at(0), 2);
    for (int p = 0; p < N; p++) add_frame(p, 1);
    run(12);
    chk("rr_after_single", log_at(1), 3);

    // Randomized traffic
    vprob = 70; rdy_mode = 1; clr_pct = 3;
    for (int t = 0; t < 700; t++) begin
      if ($urandom_range(99) < 25) begin
        mi = $urandom_range(N - 1);
        if (src_q[mi].size() < 12) add_frame(mi, $urandom_range(6, 1));
      end
      if ($urandom_range(99) < 2) en = N'($urandom);
      step();
    end
    vprob = 100; rdy_mode = 0; clr_pct = 0; en = '1;
    run(300);
    chk("drain_beats", exp_beats.size(), 0);
    chk("drain_grants", exp_grant.size(), 0);
    chk("drain_done", exp_done.size(), 0);
    for (int p = 0; p < N; p++) chk("drain_src", src_q[p].size(), 0);

    // Asynchronous reset mid-frame, then first grant to port 0
    add_frame(0, 8);
    for (c = 0; c < 50 && !(m_busy && m_cnt >= 3); c++) step();
    chk("midframe_reached", (m_busy && m_cnt >= 3), 1);
    #2;
    do_reset();
    for (int p = 0; p < N; p++) add_frame(p, 2);
    done_log.delete();
    run(20);
    chk("post_reset_first", log_at(0), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
